// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, RV32I field constants and a legality check.
// Used by both the instruction encoder and the ALU decode path.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // SUB has no immediate form in RV32I, so it is only legal as R-type.
    function automatic logic is_legal(input logic [2:0] op, input logic imm_en);
        logic ok;
        case (op)
            ALU_ADD, ALU_AND, ALU_OR, ALU_SLT: ok = 1'b1;
            ALU_SUB:                           ok = !imm_en;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_instr_fields.sv
// Combinational mapping from an ALU op request to its RV32I encoding fields.
module alu_instr_fields
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic       imm_en,
    output logic [6:0] opcode,
    output logic [2:0] funct3,
    output logic [6:0] funct7,
    output logic       legal
);

    // Select opcode/funct fields; illegal ops fall back to zero fields.
    always_comb begin
        opcode = imm_en ? OPCODE_OP_IMM : OPCODE_OP;
        funct3 = F3_ADD_SUB;
        funct7 = F7_BASE;
        legal  = is_legal(op, imm_en);
        case (op)
            ALU_ADD: funct3 = F3_ADD_SUB;
            ALU_SUB: begin
                funct3 = F3_ADD_SUB;
                funct7 = F7_SUB;
            end
            ALU_AND: funct3 = F3_AND;
            ALU_OR:  funct3 = F3_OR;
            ALU_SLT: funct3 = F3_SLT;
            default: funct3 = F3_ADD_SUB;
        endcase
    end

endmodule

// File: rtl/alu_instr_enc.sv
// ALU instruction encoder: turns op requests into RV32I R/I-type words with
// sequential byte addresses, in bounded runs of P_DEPTH words.
module alu_instr_enc
    import alu_pkg::*;
#(
    parameter int          P_DEPTH     = 16,
    parameter logic [31:0] P_BASE_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [2:0]  i_op,
    input  logic        i_imm_en,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [11:0] i_imm,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_addr,
    output logic        o_done,
    output logic [7:0]  o_err_cnt
);

    // One extra bit so the counter can hold P_DEPTH itself.
    localparam int             CW      = $clog2(P_DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(P_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] issued;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    logic [31:0] word;
    logic [31:0] next_addr;
    logic        accept;
    logic        load;
    logic        bad;
    logic        last_drain;

    alu_instr_fields u_fields (
        .op     (i_op),
        .imm_en (i_imm_en),
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .legal  (legal)
    );

    // Assemble the instruction word in R-type or I-type layout.
    always_comb begin
        if (i_imm_en) begin
            word = {i_imm, i_rs1, funct3, i_rd, opcode};
        end else begin
            word = {funct7, i_rs2, i_rs1, funct3, i_rd, opcode};
        end
    end

    // Accept only in RUN, with room in the output stage and words left in the run.
    assign o_ready    = (state == S_RUN) && !i_start && (!o_valid || i_ready) && (issued < DEPTH_C);
    assign accept     = i_valid && o_ready;
    assign load       = accept && legal;
    assign bad        = accept && !legal;
    assign next_addr  = P_BASE_ADDR + (32'(issued) << 2);
    assign last_drain = o_valid && i_ready && (issued == DEPTH_C);

    // Run FSM with the output register, word counter and error counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            issued    <= '0;
            o_valid   <= 1'b0;
            o_instr   <= '0;
            o_addr    <= P_BASE_ADDR;
            o_done    <= 1'b0;
            o_err_cnt <= '0;
        end else if (i_start) begin
            state     <= S_RUN;
            issued    <= '0;
            o_valid   <= 1'b0;
            o_addr    <= P_BASE_ADDR;
            o_done    <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (load) begin
                        o_valid <= 1'b1;
                        o_instr <= word;
                        o_addr  <= next_addr;
                        issued  <= issued + CW'(1);
                    end else if (o_valid && i_ready) begin
                        o_valid <= 1'b0;
                    end
                    if (bad && (o_err_cnt != 8'hFF)) begin
                        o_err_cnt <= o_err_cnt + 8'd1;
                    end
                    if (last_drain) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_instr_enc.sv
// Directed bench for alu_instr_enc: table of single-request encodings plus
// hand sequences for back-to-back, stall, errors, end of run and reset.
module tb_alu_instr_enc;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready_o;
    logic [2:0]  op;
    logic        imm_en;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        done;
    logic [7:0]  err_cnt;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [2:0]  op;
        logic        imm_en;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic        legal;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[12];

    alu_instr_enc #(
        .P_DEPTH     (DEPTH),
        .P_BASE_ADDR (BASE)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_valid   (in_valid),
        .o_ready   (in_ready_o),
        .i_op      (op),
        .i_imm_en  (imm_en),
        .i_rd      (rd),
        .i_rs1     (rs1),
        .i_rs2     (rs2),
        .i_imm     (imm),
        .o_valid   (out_valid),
        .i_ready   (out_ready),
        .o_instr   (instr),
        .o_addr    (addr),
        .o_done    (done),
        .o_err_cnt (err_cnt)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] o, input logic ie, input logic [4:0] d,
                                  input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im);
        op       = o;
        imm_en   = ie;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        imm      = im;
        in_valid = 1'b1;
        #1;
    endtask

    task automatic do_start();
        in_valid = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        imm_en    = 1'b0;
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        imm       = '0;

        vecs[0]  = '{3'b000, 1'b0, 5'd1,  5'd2,  5'd3,  12'h000, 1'b1, 32'h003100B3};
        vecs[1]  = '{3'b001, 1'b0, 5'd5,  5'd6,  5'd7,  12'h000, 1'b1, 32'h407302B3};
        vecs[2]  = '{3'b010, 1'b1, 5'd1,  5'd1,  5'd0,  12'hFFF, 1'b1, 32'hFFF0F093};
        vecs[3]  = '{3'b011, 1'b0, 5'd31, 5'd0,  5'd31, 12'h000, 1'b1, 32'h01F06FB3};
        vecs[4]  = '{3'b101, 1'b1, 5'd4,  5'd4,  5'd0,  12'h005, 1'b1, 32'h00522213};
        vecs[5]  = '{3'b101, 1'b0, 5'd2,  5'd3,  5'd4,  12'h000, 1'b1, 32'h0041A133};
        vecs[6]  = '{3'b000, 1'b1, 5'd10, 5'd11, 5'd0,  12'h800, 1'b1, 32'h80058513};
        vecs[7]  = '{3'b011, 1'b1, 5'd3,  5'd7,  5'd0,  12'h0A5, 1'b1, 32'h0A53E193};
        vecs[8]  = '{3'b010, 1'b0, 5'd8,  5'd9,  5'd10, 12'h000, 1'b1, 32'h00A4F433};
        vecs[9]  = '{3'b100, 1'b0, 5'd1,  5'd1,  5'd1,  12'h000, 1'b0, 32'h0};
        vecs[10] = '{3'b110, 1'b1, 5'd1,  5'd1,  5'd1,  12'h001, 1'b0, 32'h0};
        vecs[11] = '{3'b001, 1'b1, 5'd1,  5'd1,  5'd1,  12'h001, 1'b0, 32'h0};

        // Reset values
        #12;
        check_output("rst_ready", 32'(in_ready_o), 32'd0);
        check_output("rst_valid", 32'(out_valid), 32'd0);
        check_output("rst_instr", instr, 32'd0);
        check_output("rst_addr", addr, BASE);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        check_output("idle_ready", 32'(in_ready_o), 32'd0);

        // Table: one request per fresh run
        for (int i = 0; i < 12; i++) begin
            do_start();
            apply_stimulus(vecs[i].op, vecs[i].imm_en, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            check_output($sformatf("v%0d_ready", i), 32'(in_ready_o), 32'd1);
            step();
            in_valid = 1'b0;
            check_output($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].legal));
            if (vecs[i].legal) begin
                check_output($sformatf("v%0d_instr", i), instr, vecs[i].instr);
                check_output($sformatf("v%0d_addr", i), addr, BASE);
            end else begin
                check_output($sformatf("v%0d_err", i), 32'(err_cnt), 32'd1);
            end
        end

        // Back-to-back SUB then ANDI with no bubble
        do_start();
        check_output("b2b_err_cleared", 32'(err_cnt), 32'd0);
        apply_stimulus(3'b001, 1'b0, 5'd5, 5'd6, 5'd7, 12'h000);
        step();
        check_output("b2b_w0", instr, 32'h407302B3);
        check_output("b2b_a0", addr, BASE);
        apply_stimulus(3'b010, 1'b1, 5'd1, 5'd1, 5'd0, 12'hFFF);
        check_output("b2b_ready", 32'(in_ready_o), 32'd1);
        step();
        in_valid = 1'b0;
        check_output("b2b_v1", 32'(out_valid), 32'd1);
        check_output("b2b_w1", instr, 32'hFFF0F093);
        check_output("b2b_a1", addr, BASE + 32'd4);

        // Downstream stall for 3 cycles with a request waiting
        do_start();
        apply_stimulus(3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
        step();
        out_ready = 1'b0;
        apply_stimulus(3'b011, 1'b0, 5'd31, 5'd0, 5'd31, 12'h000);
        for (int c = 0; c < 3; c++) begin
            check_output($sformatf("hold%0d_ready", c), 32'(in_ready_o), 32'd0);
            check_output($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
            check_output($sformatf("hold%0d_instr", c), instr, 32'h003100B3);
            check_output($sformatf("hold%0d_addr", c), addr, BASE);
            step();
        end
        out_ready = 1'b1;
        #1;
        check_output("release_ready", 32'(in_ready_o), 32'd1);
        step();
        in_valid = 1'b0;
        check_output("release_instr", instr, 32'h01F06FB3);
        check_output("release_addr", addr, BASE + 32'd4);

        // Illegal requests are dropped without consuming an address
        do_start();
        apply_stimulus(3'b110, 1'b0, 5'd1, 5'd1, 5'd1, 12'h000);
        step();
        check_output("ill_valid0", 32'(out_valid), 32'd0);
        apply_stimulus(3'b001, 1'b1, 5'd1, 5'd1, 5'd1, 12'h001);
        step();
        apply_stimulus(3'b101, 1'b1, 5'd4, 5'd4, 5'd0, 12'h005);
        step();
        in_valid = 1'b0;
        check_output("ill_err", 32'(err_cnt), 32'd2);
        check_output("ill_valid", 32'(out_valid), 32'd1);
        check_output("ill_instr", instr, 32'h00522213);
        check_output("ill_addr", addr, BASE);

        // Full run of DEPTH words, then DONE and restart
        do_start();
        apply_stimulus(3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
        for (int k = 0; k < DEPTH; k++) begin
            step();
            check_output($sformatf("run_addr%0d", k), addr, BASE + 32'(4 * k));
        end
        check_output("run_full_ready", 32'(in_ready_o), 32'd0);
        check_output("run_not_done", 32'(done), 32'd0);
        in_valid = 1'b0;
        step();
        check_output("done_flag", 32'(done), 32'd1);
        check_output("done_valid", 32'(out_valid), 32'd0);
        check_output("done_ready", 32'(in_ready_o), 32'd0);
        do_start();
        check_output("restart_done", 32'(done), 32'd0);
        check_output("restart_addr", addr, BASE);
        check_output("restart_ready", 32'(in_ready_o), 32'd1);
        apply_stimulus(3'b101, 1'b1, 5'd4, 5'd4, 5'd0, 12'h005);
        step();
        in_valid = 1'b0;
        check_output("restart_w0_addr", addr, BASE);

        // Asynchronous reset while a word is held
        out_ready = 1'b0;
        do_start();
        apply_stimulus(3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
        step();
        in_valid = 1'b0;
        check_output("pre_rst_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("arst_valid", 32'(out_valid), 32'd0);
        check_output("arst_instr", instr, 32'd0);
        check_output("arst_addr", addr, BASE);
        check_output("arst_done", 32'(done), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        apply_stimulus(3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
        check_output("arst_idle_ready", 32'(in_ready_o), 32'd0);
        step();
        in_valid = 1'b0;
        check_output("arst_idle_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_instr_enc.md
# alu_instr_enc

Instruction encoder for the single-cycle RISC-V core: the inverse of the ALU decode path. It accepts ALU operation requests (op code, register indices, optional immediate) over a valid/ready handshake and encodes each into a 32-bit RV32I R-type or I-type instruction word. Encoded words go out over a second valid/ready handshake, each paired with a sequential instruction-memory byte address, to the instruction-memory loader used for self-test program generation. A run is a bounded program of `P_DEPTH` words; illegal requests are dropped and counted.

## Interface
- `P_DEPTH`, 16: words per run; power of two, 2..1024.
- `P_BASE_ADDR`, 32'h0000_0000: byte address of the first word; 4-byte aligned.
- `i_clk`  in  1: clock; all state changes on the rising edge.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_start`  in  1: begin a new run; sampled every cycle.
- `i_valid`  in  1: request valid.
- `o_ready`  out  1: encoder can accept a request this cycle.
- `i_op`  in  3: ALU op (`alu_pkg` codes).
- `i_imm_en`  in  1: 1 = I-type (use `i_imm`), 0 = R-type (use `i_rs2`).
- `i_rd`, `i_rs1`, `i_rs2`  in  5 each: register indices.
- `i_imm`  in  12: I-type immediate.
- `o_valid`  out  1: encoded word valid.
- `i_ready`  in  1: downstream accepts the word.
- `o_instr`  out  32: encoded instruction.
- `o_addr`  out  32: byte address of `o_instr`.
- `o_done`  out  1: run complete.
- `o_err_cnt`  out  8: count of dropped illegal requests; saturating.

## Operation
- Op codes: ADD=000, SUB=001, AND=010, OR=011, SLT=101. Codes 100, 110 and 111 are illegal. SUB with `i_imm_en`=1 is illegal, because RV32I has no subi.
- Opcode field: 0110011 when R-type, 0010011 when I-type.
- funct3 field: ADD/SUB 000, SLT 010, OR 110, AND 111.
- funct7 field: 0100000 for SUB, otherwise 0000000.
- R-type word: {funct7, rs2, rs1, funct3, rd, opcode}.
- I-type word: {imm[11:0], rs1, funct3, rd, opcode}.
- FSM states:
  - IDLE (reset state). `i_start` moves it to RUN.
  - RUN. After the `P_DEPTH`-th word is accepted downstream, it moves to DONE.
  - DONE. `i_start` moves it to RUN.
- `i_start` in any state:
  - clears the word counter, the address and `o_err_cnt`;
  - discards any held output word (`o_valid` goes to 0 next cycle);
  - enters RUN.
- `o_ready` = (state==RUN) & !i_start & (!o_valid | i_ready) & (issued < `P_DEPTH`).
  - `issued` counts words accepted into the output register during this run.
- Illegal request accepted (`i_valid & o_ready`): no word is produced, `o_err_cnt` increments (saturates at 255), and the request does not consume an address.
- Address: `o_addr` = `P_BASE_ADDR` + 4*index, where index is the word's position in the run. The index counter is log2(`P_DEPTH`)+1 bits. The address never wraps inside a run.
- `o_done` = (state==DONE).

## Timing
- Reset values: `o_ready`=0, `o_valid`=0, `o_instr`=0, `o_addr`=`P_BASE_ADDR`, `o_done`=0, `o_err_cnt`=0, state IDLE.
- Latency: a legal request accepted in cycle N gives `o_valid`=1 with the word in cycle N+1.
- Throughput: 1 word per cycle when `i_ready` stays high.
- Holding: while `o_valid & !i_ready`, `o_instr` and `o_addr` stay stable and `o_valid` stays high.
- Accept and drain in the same cycle: the output register reloads directly with no bubble.
- DONE timing: entered the cycle after the last word handshakes (`o_valid & i_ready` with `issued`==`P_DEPTH`). `o_valid`=0 from that cycle.
- Asynchronous reset mid-run: outputs return to their reset values immediately; the in-flight word is lost.

## Structure
- `alu_pkg` holds:
  - `alu_op_t` enum for the op codes;
  - opcode, funct3 and funct7 constants;
  - a pure function `is_legal(op, imm_en)`.
  The ALU decode logic shares this package.
- Sub-module `alu_instr_fields`: combinational op → {opcode, funct3, funct7, legal}.
- The FSM, counters and output register stay in the top module.

## Test plan
- Reset, then `i_start`, then ADD, `i_imm_en`=0, rd=1, rs1=2, rs2=3 → next cycle `o_instr`=32'h003100B3, `o_addr`=`P_BASE_ADDR`.
- SUB rd=5, rs1=6, rs2=7, then AND `i_imm_en`=1, rd=1, rs1=1, imm=12'hFFF with `i_ready`=1 → 32'h407302B3 then 32'hFFF0F093, addresses +0 and +4, no bubble.
- Hold `i_ready`=0 for 3 cycles with one word pending → `o_instr`/`o_addr` stable, `o_ready`=0, no request lost; release → the next word follows.
- Send op 110, then SUB with `i_imm_en`=1, then SLT rd=4, rs1=4, imm=5 → `o_err_cnt`=2; only 32'h00522213 is emitted, at address +0.
- `P_DEPTH`=4: send 4 legal requests → `o_done`=1 after the 4th handshake, `o_ready`=0; `i_start` → counters and address cleared, `o_done`=0.
- Assert `i_rst_n`=0 while `o_valid`=1 → outputs at reset values immediately; after release, IDLE with `o_ready`=0.
